// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_if_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] inst_addr_t;
  typedef logic [XLEN-1:0] inst_t;

  localparam inst_t      NOP_INST    = 32'h0000_0013;
  localparam inst_addr_t IF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic inst_addr_t word_align(input inst_addr_t a);
    return a & ~inst_addr_t'(3);
  endfunction

endpackage

// File: rtl/stage_if_fifo.sv
// {pc,inst} buffer between instruction memory and decode; flush overrides push.
module stage_if_fifo
  import stage_if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_inst,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_inst,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail] <= '{pc: push_pc, inst: push_inst};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_pc   = mem[head].pc;
  assign head_inst = mem[head].inst;
  assign empty     = (count == '0);

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: single-outstanding imem requests feeding a small {pc,inst} FIFO.
// Optional IF_PERF_EN adds saturating bubble/flush performance counters.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IF_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_bubble,
  output logic [31:0] perf_flush
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          empty;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;

  logic [31:0]   fetch_pc;
  logic [31:0]   target_pc;
  logic          pending;
  logic          kill;

  logic accept;
  logic redirect;
  logic ack;
  logic push;
  logic fifo_pop;
  logic issue;

  // A pending request owns a slot, so issuing is allowed only once it is
  // acked this cycle (or none is outstanding) and the FIFO still has room.
  always_comb begin
    accept      = !empty && !stall;
    redirect    = accept && br;
    ack         = imem_req && imem_ack;
    push        = ack && !kill && !redirect;
    fifo_pop    = accept && !redirect;
    count_after = redirect ? '0 : (count + CW'(push) - CW'(fifo_pop));
    target_pc   = redirect ? word_align(br_addr) : fetch_pc;
    issue       = (!pending || ack) && (count_after < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= word_align(RESET_PC);
      pending   <= 1'b0;
      kill      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= target_pc;
        pending   <= 1'b1;
        fetch_pc  <= target_pc + 32'd4;
      end else begin
        fetch_pc <= target_pc;
        if (ack) begin
          imem_req <= 1'b0;
          pending  <= 1'b0;
        end
      end
      // An in-flight request overtaken by a redirect returns stale data.
      if (ack) begin
        kill <= 1'b0;
      end else if (redirect && pending) begin
        kill <= 1'b1;
      end
    end
  end

  stage_if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (fifo_pop),
    .flush     (redirect),
    .push_pc   (imem_addr),
    .push_inst (imem_rdata),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (count),
    .empty     (empty)
  );

  assign inst_valid = !empty;
  assign pc         = empty ? '0 : head_pc;
  assign inst       = empty ? NOP_INST : head_inst;

`ifdef IF_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble <= '0;
      perf_flush  <= '0;
    end else begin
      if (empty && !stall && (perf_bubble != '1)) perf_bubble <= perf_bubble + 32'd1;
      if (redirect && (perf_flush != '1))         perf_flush  <= perf_flush + 32'd1;
    end
  end
`endif

endmodule
